// File: rtl/ucode_pkg.sv
// ucode_pkg: shared widths, loader states and error codes for the microcode loader
package ucode_pkg;
  localparam int WORD_W = 20;
  localparam int ADDR_W = 7;
  localparam int BYTES_PER_WORD = 3;
  localparam int MAX_WORDS = 128;
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_COUNT = 2'b01;
  localparam logic [1:0] ERR_PAD = 2'b10;
  localparam logic [1:0] ERR_CSUM = 2'b11;
endpackage

// File: rtl/ucode_word_packer.sv
// ucode_word_packer: packs little-endian bytes into control words, checks pad bits, keeps running sum
module ucode_word_packer
  import ucode_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              en,
  input  logic [7:0]        data,
  output logic              word_ready,
  output logic              pad_err,
  output logic [WORD_W-1:0] word,
  output logic [7:0]        sum
);
  logic [1:0] idx;
  logic [15:0] lo;
  logic last;
  assign last = idx == 2'(BYTES_PER_WORD - 1);
  assign word_ready = en && last && data[7:4] == 4'h0;
  assign pad_err = en && last && data[7:4] != 4'h0;
  assign word = {data[3:0], lo};
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx <= '0;
      lo <= '0;
      sum <= '0;
    end else if (init) begin
      idx <= '0;
      sum <= data;
    end else if (en) begin
      sum <= sum + data;
      idx <= last ? 2'd0 : idx + 2'd1;
      if (idx == 2'd0) lo[7:0] <= data;
      if (idx == 2'd1) lo[15:8] <= data;
    end
  end
endmodule

// File: rtl/ucode_loader.sv
// ucode_loader: loads a framed, checksummed byte stream into the microcode control store
module ucode_loader
  import ucode_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              cu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);
  state_t state, nxt;
  logic [7:0] n, sum;
  logic [1:0] ec;
  logic acc, word_ready, pad_err, bad_n, csum_ok, last_word;
  logic [WORD_W-1:0] word;
  assign rx_ready = state inside {S_HDR, S_DATA, S_CSUM};
  assign busy = rx_ready;
  assign acc = rx_valid && rx_ready;
  assign done = state == S_DONE;
  assign error = state == S_ERR;
  assign cu_hold = !done;
  assign bad_n = rx_data == 8'd0 || rx_data > 8'(MAX_WORDS);
  assign csum_ok = 8'(sum + rx_data) == 8'd0;
  // the previous word's write has always retired by the time the next third byte arrives
  assign last_word = 8'(words_loaded + 8'd1) == n;
  ucode_word_packer u_packer (
    .clk(clk),
    .reset(reset),
    .init(state == S_HDR && acc),
    .en(state == S_DATA && acc),
    .data(rx_data),
    .word_ready(word_ready),
    .pad_err(pad_err),
    .word(word),
    .sum(sum)
  );
  always_comb begin
    nxt = state;
    ec = err_code;
    case (state)
      S_HDR: if (acc) begin
        nxt = bad_n ? S_ERR : S_DATA;
        ec = bad_n ? ERR_COUNT : ec;
      end
      S_DATA: begin
        nxt = pad_err ? S_ERR : (word_ready && last_word) ? S_CSUM : state;
        ec = pad_err ? ERR_PAD : ec;
      end
      S_CSUM: if (acc) begin
        nxt = csum_ok ? S_DONE : S_ERR;
        ec = csum_ok ? ec : ERR_CSUM;
      end
      default: if (start) begin
        nxt = S_HDR;
        ec = ERR_NONE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      n <= '0;
      err_code <= ERR_NONE;
      words_loaded <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state <= nxt;
      err_code <= ec;
      wr_en <= word_ready;
      words_loaded <= (start && !busy) ? '0 : words_loaded + (ADDR_W+1)'(wr_en);
      if (state == S_HDR && acc) n <= rx_data;
      if (word_ready) begin
        wr_addr <= words_loaded[ADDR_W-1:0];
        wr_data <= word;
      end
    end
  end
endmodule

// File: tb/tb_ucode_loader.sv
// tb_ucode_loader: directed scoreboard bench for the microcode loader
module tb_ucode_loader;
  logic clk = 0, reset = 0, start = 0, rx_valid = 0;
  logic [7:0] rx_data = 0;
  logic rx_ready, wr_en, cu_hold, busy, done, error;
  logic [6:0] wr_addr;
  logic [19:0] wr_data;
  logic [1:0] err_code;
  logic [7:0] words_loaded;
  int errs = 0, checks = 0, wr_count = 0, wr_base;
  logic [7:0] tsum;
  logic [26:0] exp_q[$];

  ucode_loader dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cu_hold(cu_hold), .busy(busy), .done(done), .error(error), .err_code(err_code),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (wr_en) begin
    logic [26:0] e;
    wr_count++;
    if (exp_q.size() == 0) chk("unexpected_wr", {25'd0, wr_addr}, 32'hFFFF_FFFF);
    else begin
      e = exp_q.pop_front();
      chk("wr_addr", {25'd0, wr_addr}, {25'd0, e[26:20]});
      chk("wr_data", {12'd0, wr_data}, {12'd0, e[19:0]});
    end
  end

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    while (!rx_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) chk("rx_ready_timeout", 0, 1);
    rx_valid = 1;
    rx_data = b;
    tsum = tsum + b;
    @(negedge clk);
    rx_valid = 0;
  endtask

  task automatic send_word(input logic [19:0] w, input logic [6:0] a, input bit gaps);
    logic [7:0] bytes[3];
    bytes[0] = w[7:0];
    bytes[1] = w[15:8];
    bytes[2] = {4'h0, w[19:16]};
    exp_q.push_back({a, w});
    for (int i = 0; i < 3; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      send(bytes[i]);
    end
  endtask

  task automatic check_err(input string tag, input logic [1:0] code);
    chk({tag, "_error"}, {31'd0, error}, 1);
    chk({tag, "_code"}, {30'd0, err_code}, {30'd0, code});
    chk({tag, "_hold"}, {31'd0, cu_hold}, 1);
    chk({tag, "_done"}, {31'd0, done}, 0);
  endtask

  initial begin
    idle(2);
    chk("rst_hold", {31'd0, cu_hold}, 1);
    chk("rst_ready", {31'd0, rx_ready}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_error", {31'd0, error}, 0);
    chk("rst_code", {30'd0, err_code}, 0);
    chk("rst_wl", {24'd0, words_loaded}, 0);
    chk("rst_wr", {11'd0, wr_en, wr_addr, wr_data}, 0);
    reset = 1;
    idle(1);
    // reset in the middle of DATA
    tsum = 0;
    pulse_start();
    send(8'h02);
    send(8'h11);
    send(8'h22);
    chk("mid_busy", {31'd0, busy}, 1);
    reset = 0;
    idle(2);
    chk("mr_hold", {31'd0, cu_hold}, 1);
    chk("mr_ready", {31'd0, rx_ready}, 0);
    chk("mr_done", {31'd0, done}, 0);
    chk("mr_error", {31'd0, error}, 0);
    chk("mr_wl", {24'd0, words_loaded}, 0);
    reset = 1;
    idle(1);
    // single-word load, good checksum
    wr_base = wr_count;
    tsum = 0;
    pulse_start();
    send(8'h01);
    send_word(20'h51234, 7'd0, 0);
    send(8'hB4);
    chk("one_done", {31'd0, done}, 1);
    chk("one_hold", {31'd0, cu_hold}, 0);
    chk("one_error", {31'd0, error}, 0);
    chk("one_wl", {24'd0, words_loaded}, 1);
    chk("one_wrs", wr_count - wr_base, 1);
    // bad headers
    wr_base = wr_count;
    pulse_start();
    chk("restart_done", {31'd0, done}, 0);
    chk("restart_wl", {24'd0, words_loaded}, 0);
    send(8'h00);
    check_err("hdr00", 2'b01);
    pulse_start();
    send(8'h81);
    check_err("hdr81", 2'b01);
    // nonzero pad bits
    pulse_start();
    send(8'h01);
    send(8'h34);
    send(8'h12);
    send(8'h15);
    check_err("pad", 2'b10);
    idle(2);
    chk("bad_wrs", wr_count - wr_base, 0);
    // checksum mismatch after one write
    wr_base = wr_count;
    tsum = 0;
    pulse_start();
    send(8'h01);
    send_word(20'h51234, 7'd0, 0);
    send(8'hB5);
    check_err("csum", 2'b11);
    chk("csum_wrs", wr_count - wr_base, 1);
    chk("csum_wl", {24'd0, words_loaded}, 1);
    // full 128-word load with gaps and a stray start
    wr_base = wr_count;
    tsum = 0;
    pulse_start();
    send(8'd128);
    for (int k = 0; k < 128; k++) begin
      if (k == 60) start = 1;
      send_word(20'(k), 7'(k), 1);
      start = 0;
    end
    send(8'(0 - tsum));
    chk("full_done", {31'd0, done}, 1);
    chk("full_hold", {31'd0, cu_hold}, 0);
    chk("full_wl", {24'd0, words_loaded}, 128);
    chk("full_wrs", wr_count - wr_base, 128);
    chk("full_q", exp_q.size(), 0);
    chk("full_busy", {31'd0, busy}, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
